// File: rtl/im_cache_dm.sv
// Read-only direct-mapped instruction cache with multi-word lines and burst refill.
// Latency: hits are combinational; a miss costs NWORDS+1 cycles minimum (one per beat, plus start).
// Backpressure: mem_rdy low stalls the refill with mem_addr held; busy reports an active fill.
module im_cache_dm #(
  parameter int NBLOCKS = 4,
  parameter int NWORDS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        hit,
  output logic [31:0] data,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [31:0] mem_data,
  output logic [15:0] miss_cnt
);

  localparam int IDX_W  = $clog2(NBLOCKS);
  localparam int OFF_W  = $clog2(NWORDS);
  // Offset/beat storage needs at least one bit even for single-word lines.
  localparam int OFF_WS = (OFF_W == 0) ? 1 : OFF_W;
  localparam int TAG_W  = 30 - IDX_W - OFF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [OFF_WS-1:0]  off;
  logic [IDX_W-1:0]   fidx;
  logic [TAG_W-1:0]   ftag;
  logic [OFF_WS-1:0]  beat;
  logic               last_beat;

  logic [NBLOCKS-1:0] valid;
  logic [TAG_W-1:0]   tag_ram  [NBLOCKS];
  logic [31:0]        line_ram [NBLOCKS][NWORDS];

  // Byte offset bits carry no meaning for word fetches.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[1:0]};

  assign idx = addr[2+OFF_W +: IDX_W];
  assign tag = addr[31 -: TAG_W];

  // Single-word lines have no offset field in the address.
  generate
    if (OFF_W == 0) begin : g_no_off
      assign off = '0;
    end else begin : g_off
      assign off = addr[2 +: OFF_W];
    end
  endgenerate

  assign last_beat = (beat == OFF_WS'(NWORDS - 1));

  // Lookup on the live address; a line being refilled has its valid bit cleared.
  always_comb begin
    hit  = valid[idx] && (tag_ram[idx] == tag);
    data = hit ? line_ram[idx][off] : 32'd0;
  end

  // Refill FSM, valid bits and miss counter; flush overrides any install or fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= 32'd0;
      busy     <= 1'b0;
      miss_cnt <= 16'd0;
      fidx     <= '0;
      ftag     <= '0;
      beat     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (!hit) begin
            fidx       <= idx;
            ftag       <= tag;
            beat       <= '0;
            valid[idx] <= 1'b0;
            state      <= FILL;
            mem_req    <= 1'b1;
            busy       <= 1'b1;
            // Fill always starts at word 0 of the line.
            mem_addr   <= 32'({tag, idx, 2'b00}) << OFF_W;
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
          end
        end
        FILL: begin
          if (flush) begin
            valid   <= '0;
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
          end else if (mem_rdy) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              valid[fidx] <= 1'b1;
              state       <= IDLE;
              mem_req     <= 1'b0;
              busy        <= 1'b0;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tag capture for each accepted beat of a fill that is not being aborted.
  always_ff @(posedge clk) begin
    if (!reset && state == FILL && mem_rdy && !flush) begin
      line_ram[fidx][beat] <= mem_data;
      if (last_beat) tag_ram[fidx] <= ftag;
    end
  end

endmodule
